// File: rtl/mips_port_io.sv
// mips_port_io: memory-mapped I/O peripheral on the MIPS data-memory bus.
// A 16-byte register window provides a store-fed output FIFO with a
// valid/ready consumer port, a synchronized input port, and status/control.
module mips_port_io #(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
   parameter int          IN_WIDTH   = 8,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mem_write,
   input  logic                mem_read,
   input  logic [31:0]         address,
   input  logic [31:0]         write_data,
   output logic [31:0]         read_data,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [31:0]         PortOut,
   output logic                port_valid,
   input  logic                port_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      REG_DATA_OUT = 2'd0,
      REG_DATA_IN  = 2'd1,
      REG_STATUS   = 2'd2,
      REG_CONTROL  = 2'd3
   } reg_sel_e;

   // FIFO state
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   // Input path and sticky flags
   logic [IN_WIDTH-1:0] sync_1;
   logic [IN_WIDTH-1:0] in_sync;
   logic [IN_WIDTH-1:0] in_prev;
   logic                in_changed;
   logic                overflow;

   // Bus decode
   reg_sel_e reg_sel;
   logic     hit;
   logic     push;
   logic     ctrl_write;
   logic     flush;
   logic     clear_flags;
   logic     pop;
   logic     empty;
   logic     full;
   logic     do_push;
   logic     do_pop;
   logic     overflow_set;
   logic     change_set;
   logic     unused_addr_bits;

   // Byte lane within a word is irrelevant to this register map.
   assign unused_addr_bits = ^address[1:0];

   assign hit         = (address[31:4] == BASE_ADDR[31:4]);
   assign reg_sel     = reg_sel_e'(address[3:2]);
   assign push        = mem_write && hit && (reg_sel == REG_DATA_OUT);
   assign ctrl_write  = mem_write && hit && (reg_sel == REG_CONTROL);
   assign flush       = ctrl_write && write_data[1];
   assign clear_flags = ctrl_write && write_data[0];

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign port_valid = !empty;
   assign PortOut    = empty ? '0 : mem[rd_ptr];
   assign pop        = port_valid && port_ready;

   // Flush overrides everything; a push into a full FIFO only lands if a
   // pop frees the head slot in the same cycle.
   assign do_pop       = pop && !flush;
   assign do_push      = push && !flush && (!full || pop);
   assign overflow_set = push && !flush && full && !pop;
   assign change_set   = (in_sync != in_prev);

   // FIFO storage: written on an accepted push
   // NOTE: the storage array has no reset; count gates every read of it, so
   // stale contents are never visible and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= write_data;
      end
   end

   // FIFO pointers and occupancy count
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Two-flop synchronizer plus previous-value register for change detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1  <= '0;
         in_sync <= '0;
         in_prev <= '0;
      end else begin
         sync_1  <= PortIn;
         in_sync <= sync_1;
         in_prev <= in_sync;
      end
   end

   // Sticky status flags: a set in the same cycle as a clear wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_changed <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (change_set) begin
            in_changed <= 1'b1;
         end else if (clear_flags) begin
            in_changed <= 1'b0;
         end
         if (overflow_set) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end
      end
   end

   // Combinational load path from current registered state
   always_comb begin
      // NOTE: default first so every path assigns read_data and no latch forms.
      read_data = '0;
      if (mem_read && hit) begin
         case (reg_sel)
            REG_DATA_OUT: read_data = PortOut;
            REG_DATA_IN:  read_data = 32'(in_sync);
            REG_STATUS:   read_data = {24'd0, 4'(count), overflow, in_changed, full, empty};
            REG_CONTROL:  read_data = '0;
            default:      read_data = '0;
         endcase
      end
   end

endmodule
